// File: rtl/dp_ram_ctl.sv
// True dual-port RAM controller: two read/write ports, selectable output latency and
// same-port write read-back, collision flag. Optional clear engine via DP_RAM_INIT_EN.
module dp_ram_ctl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cea,
    input  logic              ceb,
    input  logic              ocea,
    input  logic              oceb,
    input  logic              wrea,
    input  logic              wreb,
    input  logic [ADDR_W-1:0] ada,
    input  logic [ADDR_W-1:0] adb,
    input  logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] doutb,
    input  logic              init_req,
    output logic              init_busy,
    output logic              collision
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef DP_RAM_INIT_EN
    typedef enum logic {CLEAR, READY} clr_state_e;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = READY;
            end
            READY: begin
                if (init_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;
`else
    logic unused_init_req;

    assign unused_init_req = init_req;
    assign busy            = 1'b0;
    assign clr_we          = 1'b0;
    assign clr_addr        = '0;
`endif

    assign init_busy = busy;

    logic              acc_a, acc_b, we_a, we_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Port A wins a same-address double write, so B's write is suppressed.
    assign acc_a = cea & ~busy;
    assign acc_b = ceb & ~busy;
    assign we_a  = acc_a & wrea;
    assign we_b  = acc_b & wreb & ~(we_a & (ada == adb));
    assign rd_a  = mem[ada];
    assign rd_b  = mem[adb];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we_a) mem[ada] <= dina;
            if (we_b) mem[adb] <= dinb;
        end
    end

    logic [DATA_W-1:0] s1a_q, s1a_d, s1b_q, s1b_d;
    logic              collision_q, collision_d;

    // Reads sample the array before this edge's writes land, so cross-port reads see old data.
    always_comb begin
        s1a_d = s1a_q;
        s1b_d = s1b_q;
        if (acc_a) begin
            if (!wrea)                s1a_d = rd_a;
            else if (WRITE_MODE == 1) s1a_d = dina;
            else if (WRITE_MODE == 2) s1a_d = rd_a;
        end
        if (acc_b) begin
            if (!wreb)                s1b_d = rd_b;
            else if (WRITE_MODE == 1) s1b_d = dinb;
            else if (WRITE_MODE == 2) s1b_d = rd_b;
        end
        collision_d = cea & ceb & ~busy & (ada == adb) & (wrea | wreb);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1a_q       <= '0;
            s1b_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            s1a_q       <= s1a_d;
            s1b_q       <= s1b_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    if (READ_MODE == 1) begin : g_pipe
        logic [DATA_W-1:0] s2a_q, s2a_d, s2b_q, s2b_d;

        always_comb begin
            s2a_d = s2a_q;
            s2b_d = s2b_q;
            if (ocea && !busy) s2a_d = s1a_q;
            if (oceb && !busy) s2b_d = s1b_q;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s2a_q <= '0;
                s2b_q <= '0;
            end else begin
                s2a_q <= s2a_d;
                s2b_q <= s2b_d;
            end
        end

        assign douta = s2a_q;
        assign doutb = s2b_q;
    end else begin : g_bypass
        logic unused_oce;

        assign unused_oce = ocea ^ oceb;
        assign douta      = s1a_q;
        assign doutb      = s1b_q;
    end
endmodule

// File: tb/tb_dp_ram_ctl.sv
// Bench for dp_ram_ctl: three instances (bypass/normal, pipelined/write-through,
// bypass/read-before-write) share one stimulus stream and one reference model.
module tb_dp_ram_ctl;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int W     = 6 * DW + 6;
`ifdef DP_RAM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          cea, ceb, ocea, oceb, wrea, wreb, init_req;
    logic [AW-1:0] ada, adb;
    logic [DW-1:0] dina, dinb;
    logic [DW-1:0] douta [3];
    logic [DW-1:0] doutb [3];
    logic          coll [3];
    logic          busy [3];

    always #5 clk = ~clk;

    dp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(douta[0]), .doutb(doutb[0]), .init_req(init_req), .init_busy(busy[0]),
        .collision(coll[0]));
    dp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1), .WRITE_MODE(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(douta[1]), .doutb(doutb[1]), .init_req(init_req), .init_busy(busy[1]),
        .collision(coll[1]));
    dp_ram_ctl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
        .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
        .douta(douta[2]), .doutb(doutb[2]), .init_req(init_req), .init_busy(busy[2]),
        .collision(coll[2]));

    // Reference model: memory contents, visible read value per stage, clear countdown.
    int            rm_cfg [3] = '{0, 1, 0};
    int            wm_cfg [3] = '{0, 1, 2};
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_s1 [3][2];
    logic [DW-1:0] m_s2 [3][2];
    logic          m_coll;
    int            m_clear;

    logic [W-1:0]  exp_q[$];
    bit            chk_en;
    int            n_checks;
    int            n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] act_vec();
        return {douta[0], doutb[0], douta[1], doutb[1], douta[2], doutb[2],
                coll[0], coll[1], coll[2], busy[0], busy[1], busy[2]};
    endfunction

    function automatic logic [DW-1:0] pick(input int k, input int p);
        return (rm_cfg[k] == 1) ? m_s2[k][p] : m_s1[k][p];
    endfunction

    function automatic logic [W-1:0] model_out();
        logic b;
        b = (m_clear > 0);
        return {pick(0, 0), pick(0, 1), pick(1, 0), pick(1, 1), pick(2, 0), pick(2, 1),
                m_coll, m_coll, m_coll, b, b, b};
    endfunction

    function automatic logic [DW-1:0] port_load(input int wm, input logic we,
                                                input logic [DW-1:0] cur,
                                                input logic [DW-1:0] din,
                                                input logic [DW-1:0] prior);
        if (!we) return prior;
        case (wm)
            0:       return cur;
            1:       return din;
            default: return prior;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                m_s1[k][p] = '0;
                m_s2[k][p] = '0;
            end
        end
        m_coll = 1'b0;
        if (INIT_EN) begin
            m_clear = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_a, old_b;
        if (m_clear > 0) begin
            m_clear--;
            m_coll = 1'b0;
        end else begin
            old_a = m_mem[ada];
            old_b = m_mem[adb];
            for (int k = 0; k < 3; k++) begin
                if (rm_cfg[k] == 1) begin
                    if (ocea) m_s2[k][0] = m_s1[k][0];
                    if (oceb) m_s2[k][1] = m_s1[k][1];
                end
                if (cea) m_s1[k][0] = port_load(wm_cfg[k], wrea, m_s1[k][0], dina, old_a);
                if (ceb) m_s1[k][1] = port_load(wm_cfg[k], wreb, m_s1[k][1], dinb, old_b);
            end
            m_coll = cea && ceb && (ada == adb) && (wrea || wreb);
            if (ceb && wreb) m_mem[adb] = dinb;
            if (cea && wrea) m_mem[ada] = dina;
            if (INIT_EN && init_req) begin
                m_clear = DEPTH;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        if (chk_en) exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle_inputs();
        cea = 1'b0; ceb = 1'b0; wrea = 1'b0; wreb = 1'b0;
        ocea = 1'b1; oceb = 1'b1; init_req = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_init);
        cea      = ($urandom_range(0, 3) != 0);
        ceb      = ($urandom_range(0, 3) != 0);
        wrea     = $urandom_range(0, 1) != 0;
        wreb     = $urandom_range(0, 1) != 0;
        ada      = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        adb      = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        dina     = 8'($urandom_range(0, 255));
        dinb     = 8'($urandom_range(0, 255));
        ocea     = ($urandom_range(0, 3) != 0);
        oceb     = ($urandom_range(0, 3) != 0);
        init_req = allow_init && ($urandom_range(0, 299) == 0);
    endtask

    // Pulses reset between edges and checks the asynchronous clear of every output.
    task automatic do_reset();
        logic [W-1:0] rv;
        rv = '0;
        if (INIT_EN) rv[2:0] = 3'b111;
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 check("reset_outputs", act_vec(), rv);
        #1 resetn = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle_outputs", act_vec(), exp_q.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        m_clear  = 0;
        m_coll   = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;
        idle_inputs();
        ada = '0; adb = '0; dina = '0; dinb = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Give every address a known value before any comparison is made.
        if (INIT_EN) repeat (DEPTH) tick();
        for (int i = 0; i < DEPTH / 2; i++) begin
            cea = 1'b1; wrea = 1'b1; ada = 8'(2 * i);     dina = 8'($urandom_range(0, 255));
            ceb = 1'b1; wreb = 1'b1; adb = 8'(2 * i + 1); dinb = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();
        chk_en = 1'b1;
        do_reset();

        // Clear window (random writes dropped when the engine is built in), then read everything.
        repeat (DEPTH) begin rand_inputs(1'b0); tick(); end
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle_inputs();
            cea = 1'b1; ada = 8'(2 * i);
            ceb = 1'b1; adb = 8'(2 * i + 1);
            tick();
        end

        // Write then cross-port read, bypass latency.
        idle_inputs();
        cea = 1'b1; wrea = 1'b1; ada = 8'h10; dina = 8'hA5;
        tick();
        idle_inputs();
        ceb = 1'b1; adb = 8'h10;
        tick();
        check("req030_doutb", doutb[0], 8'hA5);

        // Pipelined read: data after the second edge, held while oceb is low.
        idle_inputs();
        cea = 1'b1; wrea = 1'b1; ada = 8'h10; dina = 8'h3C;
        tick();
        idle_inputs();
        ceb = 1'b1; adb = 8'h10;
        tick();
        idle_inputs();
        tick();
        check("req031_doutb_pipe", doutb[1], 8'h3C);
        idle_inputs(); oceb = 1'b0;
        cea = 1'b1; wrea = 1'b1; ada = 8'h11; dina = 8'h99;
        tick();
        idle_inputs(); oceb = 1'b0;
        ceb = 1'b1; adb = 8'h11;
        tick();
        idle_inputs(); oceb = 1'b0;
        tick();
        check("req031_doutb_hold", doutb[1], 8'h3C);

        // Same-port read data on a write, per write mode.
        idle_inputs();
        cea = 1'b1; wrea = 1'b1; ada = 8'h21; dina = 8'h77;
        tick();
        ada = 8'h20; dina = 8'h11;
        tick();
        wrea = 1'b0; ada = 8'h21;
        tick();
        wrea = 1'b1; ada = 8'h20; dina = 8'h22;
        tick();
        check("req032_wm0_hold", douta[0], 8'h77);
        check("req032_wm2_prior", douta[2], 8'h11);
        idle_inputs();
        tick();
        check("req032_wm1_through", douta[1], 8'h22);

        // Double write to one address: A wins, collision for one cycle.
        idle_inputs();
        cea = 1'b1; wrea = 1'b1; ada = 8'h30; dina = 8'h55;
        ceb = 1'b1; wreb = 1'b1; adb = 8'h30; dinb = 8'h66;
        tick();
        check("req033_collision_set", coll[0], 1'b1);
        idle_inputs();
        tick();
        check("req033_collision_clr", coll[0], 1'b0);
        cea = 1'b1; ada = 8'h30;
        ceb = 1'b1; adb = 8'h30;
        tick();
        check("req033_read_a", douta[0], 8'h55);
        check("req033_read_b", doutb[0], 8'h55);

        repeat (1500) begin rand_inputs(1'b1); tick(); end

        // Reset mid-clear restarts the full clear.
        idle_inputs();
        do_reset();
        repeat (100) begin rand_inputs(1'b0); tick(); end
        do_reset();
        repeat (DEPTH + 200) begin rand_inputs(1'b0); tick(); end

        idle_inputs();
        repeat (3) @(negedge clk);
        #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
